// File: rtl/segment_ratio_reader_if.sv
// Bus bundle for the seven-segment read-back block: capture request and digit
// patterns in, decoded ratio plus status pulses out.
interface segment_ratio_reader_if;
   logic        sample;
   logic [6:0]  tens_hex;
   logic [6:0]  ones_hex;
   logic [31:0] ratio;
   logic        ratio_valid;
   logic        code_error;
   logic        stable_timeout;
   logic        busy;

   modport master (
      output sample, tens_hex, ones_hex,
      input  ratio, ratio_valid, code_error, stable_timeout, busy
   );

   modport slave (
      input  sample, tens_hex, ones_hex,
      output ratio, ratio_valid, code_error, stable_timeout, busy
   );
endinterface

// File: rtl/segment_ratio_reader.sv
// Reads a two-digit active-low seven-segment value back into a binary ratio,
// after the patterns have been stable for STABLE_CYCLES consecutive samples.
module segment_ratio_reader #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset,
   segment_ratio_reader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT_STABLE, DECODE} state_t;

   localparam logic [7:0]  STABLE_LIM  = 8'(STABLE_CYCLES);
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   state_t      state, state_next;
   logic [6:0]  tens_snap, tens_snap_next;
   logic [6:0]  ones_snap, ones_snap_next;
   logic [7:0]  stable_cnt, stable_cnt_next;
   logic [15:0] wait_cnt, wait_cnt_next;
   logic [6:0]  ratio_q, ratio_next;
   logic        valid_q, valid_next;
   logic        error_q, error_next;
   logic        timeout_q, timeout_next;

   logic [4:0]  tens_dec, ones_dec;
   logic [6:0]  tens_val, ones_val;
   logic [7:0]  stable_inc;
   logic [15:0] wait_inc;
   logic        inputs_match;

   // Returns {legal, digit}; any pattern outside the table is illegal.
   function automatic logic [4:0] decode_digit(input logic [6:0] code);
      case (code)
         7'b1000000: decode_digit = {1'b1, 4'd0};
         7'b1111001: decode_digit = {1'b1, 4'd1};
         7'b0100100: decode_digit = {1'b1, 4'd2};
         7'b0110000: decode_digit = {1'b1, 4'd3};
         7'b0011001: decode_digit = {1'b1, 4'd4};
         7'b0010010: decode_digit = {1'b1, 4'd5};
         7'b0000010: decode_digit = {1'b1, 4'd6};
         7'b1111000: decode_digit = {1'b1, 4'd7};
         7'b0000000: decode_digit = {1'b1, 4'd8};
         7'b0010000: decode_digit = {1'b1, 4'd9};
         default:    decode_digit = {1'b0, 4'd0};
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tens_snap  <= '0;
         ones_snap  <= '0;
         stable_cnt <= '0;
         wait_cnt   <= '0;
         ratio_q    <= '0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_next;
         tens_snap  <= tens_snap_next;
         ones_snap  <= ones_snap_next;
         stable_cnt <= stable_cnt_next;
         wait_cnt   <= wait_cnt_next;
         ratio_q    <= ratio_next;
         valid_q    <= valid_next;
         error_q    <= error_next;
         timeout_q  <= timeout_next;
      end
   end

   // tens*10 as shift-and-add; 9*10+9 fits in seven bits.
   always_comb begin
      tens_dec = decode_digit(tens_snap);
      ones_dec = decode_digit(ones_snap);
      tens_val = {3'b000, tens_dec[3:0]};
      ones_val = {3'b000, ones_dec[3:0]};
   end

   // Stability beats timeout when both would fire on the same edge.
   always_comb begin
      state_next      = state;
      tens_snap_next  = tens_snap;
      ones_snap_next  = ones_snap;
      stable_cnt_next = stable_cnt;
      wait_cnt_next   = wait_cnt;
      ratio_next      = ratio_q;
      valid_next      = 1'b0;
      error_next      = 1'b0;
      timeout_next    = 1'b0;
      stable_inc      = stable_cnt + 8'd1;
      wait_inc        = wait_cnt + 16'd1;
      inputs_match    = (bus.tens_hex == tens_snap) && (bus.ones_hex == ones_snap);

      case (state)
         IDLE: begin
            if (bus.sample) begin
               tens_snap_next  = bus.tens_hex;
               ones_snap_next  = bus.ones_hex;
               stable_cnt_next = '0;
               wait_cnt_next   = '0;
               state_next      = WAIT_STABLE;
            end
         end
         WAIT_STABLE: begin
            wait_cnt_next = wait_inc;
            if (inputs_match) begin
               stable_cnt_next = stable_inc;
            end else begin
               tens_snap_next  = bus.tens_hex;
               ones_snap_next  = bus.ones_hex;
               stable_cnt_next = '0;
            end
            if (inputs_match && (stable_inc == STABLE_LIM)) begin
               state_next = DECODE;
            end else if (wait_inc == TIMEOUT_LIM) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end
         end
         DECODE: begin
            if (tens_dec[4] && ones_dec[4]) begin
               ratio_next = (tens_val << 3) + (tens_val << 1) + ones_val;
               valid_next = 1'b1;
            end else begin
               error_next = 1'b1;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.ratio          = {25'd0, ratio_q};
   assign bus.ratio_valid    = valid_q;
   assign bus.code_error     = error_q;
   assign bus.stable_timeout = timeout_q;
   assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_segment_ratio_reader.sv
// Directed bench for segment_ratio_reader: an edge-indexed reference model is
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_segment_ratio_reader;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 16;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_BAD = 7'b1111111;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   segment_ratio_reader_if bus ();

   segment_ratio_reader #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] tens, input logic [6:0] ones);
      bus.tens_hex = tens;
      bus.ones_hex = ones;
   endtask

   // Reference model: tracks the pending request by edge index and judges
   // stability from the input trace itself.
   logic [6:0]  legal_codes [10] = '{SEG_0, 7'b1111001, SEG_2, 7'b0110000, SEG_4,
                                     SEG_5, 7'b0000010, SEG_7, SEG_8, SEG_9};
   int          edge_n, acc_edge, run_len;
   bit          pending, decode_due;
   logic [6:0]  prev_t, prev_o;
   logic [31:0] exp_ratio;
   bit          exp_valid, exp_err, exp_to, exp_busy;

   function automatic int digit_of(input logic [6:0] code);
      digit_of = -1;
      for (int i = 0; i < 10; i++)
         if (legal_codes[i] == code) digit_of = i;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         edge_n = 0; pending = 0; decode_due = 0; run_len = 0; acc_edge = 0;
         prev_t = '0; prev_o = '0;
         exp_ratio = 0; exp_valid = 0; exp_err = 0; exp_to = 0; exp_busy = 0;
      end else begin
         exp_valid = 0; exp_err = 0; exp_to = 0;
         if (decode_due) begin
            decode_due = 0;
            exp_busy   = 0;
            if (digit_of(prev_t) >= 0 && digit_of(prev_o) >= 0) begin
               exp_ratio = 32'(digit_of(prev_t) * 10 + digit_of(prev_o));
               exp_valid = 1;
            end else begin
               exp_err = 1;
            end
         end else if (pending) begin
            if (bus.tens_hex == prev_t && bus.ones_hex == prev_o) run_len++;
            else run_len = 0;
            prev_t = bus.tens_hex;
            prev_o = bus.ones_hex;
            if (run_len == STABLE) begin
               pending = 0; decode_due = 1;
            end else if (edge_n - acc_edge == TIMEOUT) begin
               pending = 0; exp_to = 1; exp_busy = 0;
            end
         end else if (bus.sample) begin
            pending = 1; acc_edge = edge_n; run_len = 0; exp_busy = 1;
            prev_t = bus.tens_hex;
            prev_o = bus.ones_hex;
         end
         edge_n++;
      end
   end

   // Single compare point, half a cycle after each edge.
   always @(negedge clock) begin
      if (!reset) begin
         checkOutput("model_ratio", bus.ratio, exp_ratio);
         checkOutput("model_ratio_valid", 32'(bus.ratio_valid), 32'(exp_valid));
         checkOutput("model_code_error", 32'(bus.code_error), 32'(exp_err));
         checkOutput("model_stable_timeout", 32'(bus.stable_timeout), 32'(exp_to));
         checkOutput("model_busy", 32'(bus.busy), 32'(exp_busy));
      end
   end

   // Pulses sample for the accept edge; returns busy seen right after it.
   task automatic request(output int busy_cnt);
      @(negedge clock); #1;
      bus.sample = 1'b1;
      @(posedge clock); #1;
      bus.sample = 1'b0;
      busy_cnt = int'(bus.busy);
   endtask

   task automatic waitResult(input int start, output int edges, inout int busy_cnt);
      edges = start;
      forever begin
         @(posedge clock); #1;
         edges++;
         busy_cnt += int'(bus.busy);
         if (bus.ratio_valid || bus.code_error || bus.stable_timeout) break;
         if (edges > 60) begin
            checkOutput("result_wait_bound", 32'(edges), 32'd0);
            break;
         end
      end
   endtask

   initial begin
      int edges, busy_cnt, pulses;
      bus.sample = 1'b0;
      applyStimulus(SEG_0, SEG_0);
      #1;
      checkOutput("reset_ratio", bus.ratio, 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_pulses", 32'({bus.ratio_valid, bus.code_error, bus.stable_timeout}), 32'd0);
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;

      $display("[TB] scenario 1: 25 with stable inputs");
      applyStimulus(SEG_2, SEG_5);
      request(busy_cnt);
      waitResult(0, edges, busy_cnt);
      checkOutput("t1_latency", 32'(edges), 32'd5);
      checkOutput("t1_ratio", bus.ratio, 32'd25);
      checkOutput("t1_valid", 32'(bus.ratio_valid), 32'd1);
      checkOutput("t1_busy_cycles", 32'(busy_cnt), 32'd5);
      @(posedge clock); #1;
      checkOutput("t1_valid_one_cycle", 32'(bus.ratio_valid), 32'd0);

      $display("[TB] scenario 3: illegal ones pattern");
      applyStimulus(SEG_2, SEG_BAD);
      request(busy_cnt);
      waitResult(0, edges, busy_cnt);
      checkOutput("t3_latency", 32'(edges), 32'd5);
      checkOutput("t3_code_error", 32'(bus.code_error), 32'd1);
      checkOutput("t3_no_valid", 32'(bus.ratio_valid), 32'd0);
      checkOutput("t3_ratio_kept", bus.ratio, 32'd25);

      $display("[TB] scenario 2: 99 then 0");
      applyStimulus(SEG_9, SEG_9);
      request(busy_cnt);
      waitResult(0, edges, busy_cnt);
      checkOutput("t2_ratio_99", bus.ratio, 32'd99);
      checkOutput("t2_valid_99", 32'(bus.ratio_valid), 32'd1);
      applyStimulus(SEG_0, SEG_0);
      request(busy_cnt);
      waitResult(0, edges, busy_cnt);
      checkOutput("t2_ratio_0", bus.ratio, 32'd0);
      checkOutput("t2_valid_0", 32'(bus.ratio_valid), 32'd1);

      $display("[TB] scenario 4: glitch restarts stability count");
      applyStimulus(SEG_2, SEG_5);
      request(busy_cnt);
      @(posedge clock); #1;
      applyStimulus(SEG_2, SEG_7);
      @(posedge clock); #1;
      bus.sample = 1'b1;
      @(posedge clock); #1;
      bus.sample = 1'b0;
      waitResult(3, edges, busy_cnt);
      checkOutput("t4_latency", 32'(edges), 32'd7);
      checkOutput("t4_ratio", bus.ratio, 32'd27);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         pulses += int'(bus.ratio_valid) + int'(bus.code_error) + int'(bus.stable_timeout);
      end
      checkOutput("t4_no_extra_result", 32'(pulses), 32'd0);

      $display("[TB] scenario 5: stability timeout");
      applyStimulus(SEG_2, SEG_5);
      request(busy_cnt);
      edges = 0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clock); #1;
         edges = e;
         if (bus.ratio_valid || bus.code_error || bus.stable_timeout) break;
         if (e % 2 == 0) applyStimulus(SEG_2, (bus.ones_hex == SEG_5) ? SEG_7 : SEG_5);
      end
      checkOutput("t5_latency", 32'(edges), 32'(TIMEOUT));
      checkOutput("t5_timeout", 32'(bus.stable_timeout), 32'd1);
      checkOutput("t5_ratio_kept", bus.ratio, 32'd27);
      checkOutput("t5_busy_drop", 32'(bus.busy), 32'd0);

      $display("[TB] scenario 6: async reset mid-wait");
      applyStimulus(SEG_4, SEG_8);
      request(busy_cnt);
      @(posedge clock); #1;
      @(posedge clock); #3;
      reset = 1'b1;
      #1;
      checkOutput("t6_reset_ratio", bus.ratio, 32'd0);
      checkOutput("t6_reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("t6_reset_pulses", 32'({bus.ratio_valid, bus.code_error, bus.stable_timeout}), 32'd0);
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
      request(busy_cnt);
      waitResult(0, edges, busy_cnt);
      checkOutput("t6_latency", 32'(edges), 32'd5);
      checkOutput("t6_ratio", bus.ratio, 32'd48);
      checkOutput("t6_valid", 32'(bus.ratio_valid), 32'd1);

      repeat (3) @(posedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_ratio_reader.md
Name: segment_ratio_reader

Overview:
- Reads back a two-digit decimal value from a pair of active-low seven-segment digit patterns (tens, ones) and converts it to a 32-bit binary ratio.
- Inverse of the ratio-to-display path. Sits between the display bus (or a loopback/self-check tap on it) and any logic that consumes a binary ratio.
- On a capture request, the input patterns must hold stable for a programmable number of cycles before they are decoded and range-checked.
- Produces a one-cycle result strobe, an illegal-code flag, or a stability-timeout flag.

Parameters:
- STABLE_CYCLES, 4: consecutive matching samples required before decode; legal range 1..255.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for stability before abort; must exceed STABLE_CYCLES; legal range up to 65535.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample  input  1  capture request; honoured only when busy=0.
- tens_hex  input  7  tens-digit segment pattern, active-low, bit 6 = segment g … bit 0 = segment a.
- ones_hex  input  7  ones-digit segment pattern, same encoding as tens_hex.
- ratio  output  32  decoded value tens*10+ones, zero-extended; holds its last good value.
- ratio_valid  output  1  one-cycle pulse when ratio is updated.
- code_error  output  1  one-cycle pulse when a pattern is not a legal digit.
- stable_timeout  output  1  one-cycle pulse when the stability wait expires.
- busy  output  1  high in WAIT_STABLE and DECODE.

Behaviour:
- Reset (async, active-high): state=IDLE; ratio=0; ratio_valid=0; code_error=0; stable_timeout=0; busy=0; snapshot registers and counters cleared. Reset asserted mid-operation aborts the operation with no pulse of any kind.
- Legal digit codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Every other 7-bit value is illegal.
- IDLE:
  - sample=1 → latch tens_hex/ones_hex into the snapshot registers, clear stable_cnt and wait_cnt, go to WAIT_STABLE.
  - sample=0 → remain in IDLE.
- WAIT_STABLE, evaluated every edge:
  - wait_cnt increments.
  - If inputs equal the snapshot, stable_cnt increments.
  - If they differ, reload the snapshot from the inputs and set stable_cnt=0.
  - Incremented stable_cnt == STABLE_CYCLES → DECODE.
  - Otherwise, incremented wait_cnt == TIMEOUT_CYCLES → pulse stable_timeout, go to IDLE, ratio unchanged.
  - If stability and timeout occur on the same edge, stability wins.
- DECODE (one cycle):
  - Map both snapshot patterns through the code table.
  - Both legal → ratio <= tens*10 + ones (range 0..99), ratio_valid pulses, go to IDLE.
  - Either illegal → code_error pulses, ratio unchanged, go to IDLE.
- Latency: with inputs stable, ratio and ratio_valid update on edge STABLE_CYCLES+1 after the edge that accepted sample. Each input glitch restarts the stability count.
- sample while busy=1 is ignored, not queued.
- sample asserted in the same cycle that a pulse is emitted is accepted; state is IDLE on that edge's next cycle, so back-to-back requests are spaced by at least one IDLE cycle.
- ratio_valid, code_error and stable_timeout are mutually exclusive and never high for more than one cycle.
- The multiply-by-10 is implemented as (t<<3)+(t<<1) on a 7-bit intermediate, then zero-extended; no overflow is possible.

Test Plan:
1. reset released, tens=0100100 (2), ones=0010010 (5), sample pulse; STABLE_CYCLES=4 → ratio=25, ratio_valid high for exactly one cycle, 5 edges after the sample edge; busy high for 5 cycles.
2. tens=0010000 (9), ones=0010000 (9), then tens=ones=1000000 (0) → ratio=99, then ratio=0; each request gets one ratio_valid pulse.
3. After ratio=25, ones=1111111, sample → code_error pulse only, ratio stays 25, no ratio_valid.
4. Glitch: ones changes from 5 to 7 (1111000) two edges into WAIT_STABLE → count restarts, ratio=27, latency extended by 2 edges; sample pulses during busy produce no extra result.
5. TIMEOUT_CYCLES=16, ones toggling every 2 cycles → stable_timeout pulse 16 edges after acceptance, ratio unchanged, busy drops.
6. Assert reset mid-WAIT_STABLE → all outputs 0 immediately (asynchronously), no pulses; a fresh sample afterwards decodes normally.
